pes_piso: RTL and testbench

PES_PISO -- requirements
Module: pes_piso

---
 rtl/pes_pkg.sv | 19 +
 rtl/pes_bit_cnt.sv | 33 +++
 rtl/pes_piso.sv | 93 +++++++++
 tb/tb_pes_piso.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/pes_pkg.sv
// Shared types and constants for the PES parallel-in/serial-out block.
// Defining PES_PISO_PARITY_EN appends one even-parity bit to every frame.
package pes_pkg;

    localparam int unsigned WIDTH_DEF = 4;

    typedef logic [0:0] state_t;
    localparam state_t IDLE  = 1'b0;
    localparam state_t SHIFT = 1'b1;

    function automatic int unsigned frame_len(input int unsigned width);
`ifdef PES_PISO_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/pes_bit_cnt.sv
// Wrapping frame bit counter: counts 0..LEN-1 while enabled and flags the last bit.
module pes_bit_cnt #(
    parameter int unsigned LEN = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic last
);

    localparam int unsigned CW = (LEN > 1) ? $clog2(LEN) : 1;
    localparam logic [CW-1:0] MAX = CW'(LEN - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign last = (cnt_q == MAX);

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = last ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pes_piso.sv
// LSB-first parallel-in/serial-out shifter with valid/ready input and back-to-back frames.
// Optional PES_PISO_PARITY_EN appends an even-parity bit after the data bits.
module pes_piso
    import pes_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_last,
    output logic             busy
);

    localparam int unsigned FRAME_LEN = frame_len(WIDTH);

    state_t               state_q, state_d;
    logic [FRAME_LEN-1:0] frame_q, frame_d;
    logic [FRAME_LEN-1:0] new_frame;
    logic                 init_q;
    logic                 cnt_last;
    logic                 xfer;

`ifdef PES_PISO_PARITY_EN
    assign new_frame = {^in_data, in_data};
`else
    assign new_frame = in_data;
`endif

    assign busy       = (state_q == SHIFT);
    assign sout_valid = busy;
    // Frame bit k always sits in frame_q[0], so sout comes straight from a flop.
    assign sout       = frame_q[0];
    assign frame_last = busy & cnt_last;
    // init_q holds off acceptance until the first clock edge after reset release.
    assign in_ready   = init_q & (~busy | cnt_last);
    assign xfer       = in_valid & in_ready;

    pes_bit_cnt #(
        .LEN(FRAME_LEN)
    ) u_bit_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (busy),
        .last (cnt_last)
    );

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = SHIFT;
                    frame_d = new_frame;
                end
            end
            SHIFT: begin
                if (cnt_last) begin
                    if (xfer) begin
                        frame_d = new_frame;
                    end else begin
                        state_d = IDLE;
                        frame_d = '0;
                    end
                end else begin
                    frame_d = frame_q >> 1;
                end
            end
            default: begin
                state_d = IDLE;
                frame_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            frame_q <= '0;
            init_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            frame_q <= frame_d;
            init_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pes_piso.sv
// Directed self-checking bench for pes_piso (WIDTH=4) with a downstream SIPO model.
module tb_pes_piso;

`ifdef PES_PISO_PARITY_EN
    localparam int FL = 5;
`else
    localparam int FL = 4;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] in_data = 4'h0;
    logic       in_valid = 1'b0;
    logic       in_ready, sout, sout_valid, frame_last, busy;
    logic [3:0] sipo;
    int         passed = 0;
    int         total = 0;

    always #5 clk = ~clk;

    pes_piso #(
        .WIDTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sout      (sout),
        .sout_valid(sout_valid),
        .frame_last(frame_last),
        .busy      (busy)
    );

    // Downstream shift register fed LSB first; only the data bits are kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sipo <= 4'h0;
        else if (sout_valid && !(FL == 5 && frame_last)) sipo <= {sout, sipo[3:1]};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12 rst_n = 1'b1;
        repeat (5) tick();
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (sout !== 1'b0) $display("FAIL reset_sout: got %b want 0", sout); else passed++;
        total++; if (sout_valid !== 1'b0) $display("FAIL reset_sout_valid: got %b want 0", sout_valid); else passed++;
        total++; if (frame_last !== 1'b0) $display("FAIL reset_frame_last: got %b want 0", frame_last); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    endtask

    task automatic test_single();
        logic [3:0] exp = 4'hA;
        in_data = 4'hA; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 4'h5;
        for (int i = 0; i < FL; i++) begin
            if (i < 4) begin
                total++; if (sout !== exp[i]) $display("FAIL single_sout bit %0d: got %b want %b", i, sout, exp[i]); else passed++;
            end
            total++; if (sout_valid !== 1'b1) $display("FAIL single_valid bit %0d: got %b want 1", i, sout_valid); else passed++;
            total++; if (frame_last !== (i == FL - 1)) $display("FAIL single_last bit %0d: got %b want %b", i, frame_last, i == FL - 1); else passed++;
            total++; if (in_ready !== (i == FL - 1)) $display("FAIL single_ready bit %0d: got %b want %b", i, in_ready, i == FL - 1); else passed++;
            tick();
        end
        total++; if (busy !== 1'b0) $display("FAIL single_idle_busy: got %b want 0", busy); else passed++;
        total++; if (sout_valid !== 1'b0) $display("FAIL single_idle_valid: got %b want 0", sout_valid); else passed++;
        total++; if (sipo !== 4'hA) $display("FAIL single_sipo: got %h want a", sipo); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] w0 = 4'hA;
        logic [3:0] w1 = 4'h3;
        logic [3:0] exp;
        in_data = w0; in_valid = 1'b1;
        tick();
        in_data = w1;
        for (int i = 0; i < 2 * FL; i++) begin
            if (i == FL) in_valid = 1'b0;
            exp = (i < FL) ? w0 : w1;
            if ((i % FL) < 4) begin
                total++; if (sout !== exp[i % FL]) $display("FAIL b2b_sout bit %0d: got %b want %b", i, sout, exp[i % FL]); else passed++;
            end
            total++; if (sout_valid !== 1'b1) $display("FAIL b2b_valid bit %0d: got %b want 1", i, sout_valid); else passed++;
            total++; if (frame_last !== ((i % FL) == FL - 1)) $display("FAIL b2b_last bit %0d: got %b", i, frame_last); else passed++;
            tick();
        end
        total++; if (busy !== 1'b0) $display("FAIL b2b_end_busy: got %b want 0", busy); else passed++;
        total++; if (sipo !== 4'h3) $display("FAIL b2b_sipo: got %h want 3", sipo); else passed++;
    endtask

    task automatic test_valid_toggle();
        in_data = 4'h6; in_valid = 1'b1;
        tick();
        in_data = 4'hF;
        for (int i = 0; i < FL; i++) begin
            in_valid = (i < FL - 1) ? ((i % 2) == 0) : 1'b0;
            total++; if (in_ready !== (i == FL - 1)) $display("FAIL toggle_ready bit %0d: got %b want %b", i, in_ready, i == FL - 1); else passed++;
            tick();
        end
        in_valid = 1'b0;
        total++; if (sout_valid !== 1'b0) $display("FAIL toggle_no_extra: got %b want 0", sout_valid); else passed++;
        total++; if (sipo !== 4'h6) $display("FAIL toggle_sipo: got %h want 6", sipo); else passed++;
    endtask

    task automatic test_reset_midframe();
        in_data = 4'hF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        total++; if (sout !== 1'b1) $display("FAIL mid_bit2: got %b want 1", sout); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (sout !== 1'b0) $display("FAIL mid_rst_sout: got %b want 0", sout); else passed++;
        total++; if (sout_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b want 0", sout_valid); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b want 0", busy); else passed++;
        total++; if (frame_last !== 1'b0) $display("FAIL mid_rst_last: got %b want 0", frame_last); else passed++;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++; if (sout_valid !== 1'b0) $display("FAIL mid_after_valid cyc %0d: got %b want 0", i, sout_valid); else passed++;
        end
        total++; if (in_ready !== 1'b1) $display("FAIL mid_after_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_parity();
        logic [4:0] exp = 5'b1_0111;
        in_data = 4'h7; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < FL; i++) begin
            total++; if (sout !== exp[i]) $display("FAIL par_sout bit %0d: got %b want %b", i, sout, exp[i]); else passed++;
            total++; if (frame_last !== (i == FL - 1)) $display("FAIL par_last bit %0d: got %b want %b", i, frame_last, i == FL - 1); else passed++;
            tick();
        end
        total++; if (busy !== 1'b0) $display("FAIL par_end_busy: got %b want 0", busy); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_valid_toggle();
        test_reset_midframe();
        test_parity();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
